// File: rtl/scan_seq_pkg.sv
// -----------------------------------------------------------------------------
// scan_seq_pkg
//   Shared definitions for the raster-scan sequencer.
//
//   Contents:
//     state_t     - sequencer FSM state encoding (IDLE / RUN / DONE)
//     width_of()  - counter width for a 0..n-1 range, never below 1 bit
// -----------------------------------------------------------------------------
package scan_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A range of one value (n == 1) still needs a 1-bit register, so $clog2
  // alone is not enough here.
  function automatic int width_of(input int n);
    if (n > 1) begin
      return $clog2(n);
    end
    return 1;
  endfunction

endpackage : scan_seq_pkg

// File: rtl/iter.sv
// -----------------------------------------------------------------------------
// iter
//   Single up-counting iterator running 0..MAX_VALUE.
//
//   Parameters:
//     MAX_VALUE - last value the iterator reaches
//     WIDTH     - counter width (must hold MAX_VALUE)
//
//   Ports:
//     clk      in   clock
//     reset    in   synchronous clear to 0 (the owner ORs its own clear terms
//                   into this input); has priority over advance
//     advance  in   step the iterator by one
//     value    out  current iterator value
//     done     out  value == MAX_VALUE
// -----------------------------------------------------------------------------
module iter
  import scan_seq_pkg::*;
#(
  parameter int MAX_VALUE = 1,
  parameter int WIDTH     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  output logic [WIDTH-1:0] value,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);

  logic [WIDTH-1:0] value_reg;
  logic [WIDTH-1:0] value_next;
  logic             at_max;

  assign at_max = (value_reg == MAX_V);

  // The iterator saturates at MAX_VALUE instead of wrapping; the owner is
  // expected to clear it explicitly when it moves past the end of the range.
  always_comb begin
    value_next = value_reg;
    if (advance && !at_max) begin
      value_next = value_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_reg <= '0;
    end else begin
      value_reg <= value_next;
    end
  end

  assign value = value_reg;
  assign done  = at_max;

endmodule : iter

// File: rtl/scan_seq.sv
// -----------------------------------------------------------------------------
// scan_seq
//   Raster-scan sequencer: walks x (inner, 0..COLS-1) and y (outer,
//   0..ROWS-1) over a COLS x ROWS region, one coordinate per valid/ready
//   transfer, and pulses done for one cycle after the final transfer.
//
//   Optional feature macro: SCAN_SEQ_ABORT_EN
//     When defined, adds an `abort` input that ends a running scan
//     immediately (no done pulse). Undefined: no abort port.
//
//   Parameters:
//     COLS, ROWS        - region size (each >= 1)
//     X_WIDTH, Y_WIDTH  - coordinate widths (>= 1)
//
//   Ports:
//     clk        in   clock
//     reset      in   synchronous active-high reset
//     abort      in   (SCAN_SEQ_ABORT_EN only) cancel a running scan
//     start      in   request a scan; accepted only in IDLE
//     busy       out  high in RUN and DONE
//     out_valid  out  x/y/eol/last are valid
//     out_ready  in   consumer accepts the current coordinate
//     x, y       out  current coordinate
//     eol        out  last column of a row (qualified by out_valid)
//     last       out  last coordinate of the scan (qualified by out_valid)
//     done       out  one-cycle pulse after the final transfer
// -----------------------------------------------------------------------------
module scan_seq
  import scan_seq_pkg::*;
#(
  parameter int COLS    = 640,
  parameter int ROWS    = 480,
  parameter int X_WIDTH = width_of(COLS),
  parameter int Y_WIDTH = width_of(ROWS)
) (
  input  logic               clk,
  input  logic               reset,
`ifdef SCAN_SEQ_ABORT_EN
  input  logic               abort,
`endif
  input  logic               start,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [X_WIDTH-1:0] x,
  output logic [Y_WIDTH-1:0] y,
  output logic               eol,
  output logic               last,
  output logic               done
);

  state_t state_reg;
  state_t state_next;

  logic in_run;
  logic transfer;
  logic start_ok;
  logic abort_run;

  logic x_done;
  logic y_done;
  logic eol_raw;
  logic last_raw;

  logic x_clear;
  logic y_clear;
  logic y_advance;

  logic [X_WIDTH-1:0] x_value;
  logic [Y_WIDTH-1:0] y_value;

  assign in_run   = (state_reg == RUN);
  assign transfer = in_run & out_ready;

`ifdef SCAN_SEQ_ABORT_EN
  // abort only matters while a scan is running, and wins over a
  // simultaneous start in IDLE.
  assign abort_run = in_run & abort;
  assign start_ok  = (state_reg == IDLE) & start & ~abort;
`else
  assign abort_run = 1'b0;
  assign start_ok  = (state_reg == IDLE) & start;
`endif

  assign eol_raw  = x_done;
  assign last_raw = x_done & y_done;

  // Each iterator is reset whenever a scan (re)starts or leaves its range;
  // nothing depends on a counter wrapping on its own.
  assign x_clear   = reset | start_ok | (transfer & eol_raw)  | abort_run;
  assign y_clear   = reset | start_ok | (transfer & last_raw) | abort_run;
  assign y_advance = transfer & eol_raw;

  iter #(
    .MAX_VALUE (COLS - 1),
    .WIDTH     (X_WIDTH)
  ) u_x_iter (
    .clk     (clk),
    .reset   (x_clear),
    .advance (transfer),
    .value   (x_value),
    .done    (x_done)
  );

  iter #(
    .MAX_VALUE (ROWS - 1),
    .WIDTH     (Y_WIDTH)
  ) u_y_iter (
    .clk     (clk),
    .reset   (y_clear),
    .advance (y_advance),
    .value   (y_value),
    .done    (y_done)
  );

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_ok) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (abort_run) begin
          state_next = IDLE;
        end else if (transfer && last_raw) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // start is deliberately not looked at here.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs (all derived from registered state)
  // ---------------------------------------------------------------------------
  assign busy      = (state_reg == RUN) | (state_reg == DONE);
  assign out_valid = in_run;
  assign done      = (state_reg == DONE);
  assign x         = x_value;
  assign y         = y_value;
  // With COLS == 1 the x iterator is permanently at its end, so the flags are
  // gated to stay quiet outside RUN.
  assign eol       = in_run & eol_raw;
  assign last      = in_run & last_raw;

endmodule : scan_seq

// File: tb/tb_scan_seq.sv
// -----------------------------------------------------------------------------
// tb_scan_seq
//   Three sequencers side by side: 3x2, 1x1 and 4x1. A reference model keeps
//   each scan as a phase plus a linear transfer index k; the expected
//   coordinate is (k % COLS, k / COLS). Directed tests add literal checks.
// -----------------------------------------------------------------------------
module tb_scan_seq;
  import scan_seq_pkg::*;

  localparam int NDUT = 3;
  localparam int COLS_A [NDUT] = '{3, 1, 4};
  localparam int ROWS_A [NDUT] = '{2, 1, 1};

  logic clk;
  logic rst_v   [NDUT];
  logic start_v [NDUT];
  logic ready_v [NDUT];
  logic abort_v [NDUT];

  logic       d_busy  [NDUT];
  logic       d_valid [NDUT];
  logic       d_eol   [NDUT];
  logic       d_last  [NDUT];
  logic       d_done  [NDUT];
  logic [7:0] d_x     [NDUT];
  logic [7:0] d_y     [NDUT];

  int n_pass;
  int n_total;

  // model state: phase 0=idle 1=run 2=done, k = transfers so far in this scan
  int m_ph   [NDUT];
  int m_k    [NDUT];
  int done_cnt [NDUT];
  int log0 [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    localparam int C  = COLS_A[gi];
    localparam int R  = ROWS_A[gi];
    localparam int XW = width_of(C);
    localparam int YW = width_of(R);
    logic [XW-1:0] gx;
    logic [YW-1:0] gy;

    scan_seq #(
      .COLS    (C),
      .ROWS    (R),
      .X_WIDTH (XW),
      .Y_WIDTH (YW)
    ) u_dut (
      .clk       (clk),
      .reset     (rst_v[gi]),
`ifdef SCAN_SEQ_ABORT_EN
      .abort     (abort_v[gi]),
`endif
      .start     (start_v[gi]),
      .busy      (d_busy[gi]),
      .out_valid (d_valid[gi]),
      .out_ready (ready_v[gi]),
      .x         (gx),
      .y         (gy),
      .eol       (d_eol[gi]),
      .last      (d_last[gi]),
      .done      (d_done[gi])
    );

    assign d_x[gi] = 8'(gx);
    assign d_y[gi] = 8'(gy);
  end

  task automatic chk(input string nm, input int g, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s dut%0d: got %0d, expected %0d", nm, g, act, exp);
    end
  endtask

  task automatic model_update();
    for (int g = 0; g < NDUT; g++) begin
      int n;
      n = COLS_A[g] * ROWS_A[g];
      if (rst_v[g]) begin
        m_ph[g] = 0;
        m_k[g]  = 0;
      end else if (m_ph[g] == 0) begin
        if (start_v[g] && !abort_v[g]) begin
          m_ph[g] = 1;
          m_k[g]  = 0;
        end
      end else if (m_ph[g] == 1) begin
        if (abort_v[g]) begin
          m_ph[g] = 0;
          m_k[g]  = 0;
        end else if (ready_v[g]) begin
          if (m_k[g] == n - 1) begin
            m_ph[g] = 2;
            m_k[g]  = 0;
          end else begin
            m_k[g] = m_k[g] + 1;
          end
        end
      end else begin
        m_ph[g] = 0;
      end
    end
  endtask

  task automatic compare_all();
    for (int g = 0; g < NDUT; g++) begin
      int c, n, ev, ex, ey, eeol, elast;
      c     = COLS_A[g];
      n     = COLS_A[g] * ROWS_A[g];
      ev    = (m_ph[g] == 1) ? 1 : 0;
      ex    = ev ? (m_k[g] % c) : 0;
      ey    = ev ? (m_k[g] / c) : 0;
      eeol  = (ev && (m_k[g] % c == c - 1)) ? 1 : 0;
      elast = (ev && (m_k[g] == n - 1)) ? 1 : 0;
      chk("busy",  g, int'(d_busy[g]),  (m_ph[g] != 0) ? 1 : 0);
      chk("valid", g, int'(d_valid[g]), ev);
      chk("done",  g, int'(d_done[g]),  (m_ph[g] == 2) ? 1 : 0);
      chk("x",     g, int'(d_x[g]),     ex);
      chk("y",     g, int'(d_y[g]),     ey);
      chk("eol",   g, int'(d_eol[g]),   eeol);
      chk("last",  g, int'(d_last[g]),  elast);
      if (d_done[g]) done_cnt[g]++;
    end
  endtask

  // One clock: log DUT0 transfers, let the edge happen, advance the model,
  // then compare at the falling edge. Callers change inputs after return.
  task automatic tick();
    if (d_valid[0] && ready_v[0]) begin
      log0.push_back(int'(d_y[0]) * 16 + int'(d_x[0]));
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic chk_log6(input string nm);
    int exp_log [6];
    exp_log = '{0, 1, 2, 16, 17, 18};
    chk({nm, "_len"}, 0, log0.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk({nm, "_coord"}, 0, (i < log0.size()) ? log0[i] : -1, exp_log[i]);
    end
  endtask

  // run DUT0 with ready=1 until done, bounded
  task automatic run0_to_done(input string nm);
    int seen;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (d_done[0]) begin
        seen = 1;
        break;
      end
    end
    chk({nm, "_done_seen"}, 0, seen, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, lastc, d0;
    n_pass  = 0;
    n_total = 0;
    for (int g = 0; g < NDUT; g++) begin
      rst_v[g] = 1'b1; start_v[g] = 1'b0; ready_v[g] = 1'b0; abort_v[g] = 1'b0;
      m_ph[g] = 0; m_k[g] = 0; done_cnt[g] = 0;
    end
    @(negedge clk);
    tick();
    tick();
    // reset state
    chk("rst_busy",  0, int'(d_busy[0]),  0);
    chk("rst_valid", 0, int'(d_valid[0]), 0);
    chk("rst_done",  0, int'(d_done[0]),  0);
    chk("rst_x",     0, int'(d_x[0]),     0);
    chk("rst_y",     0, int'(d_y[0]),     0);
    for (int g = 0; g < NDUT; g++) rst_v[g] = 1'b0;
    tick();

    // T1: 3x2, ready always high
    log0.delete();
    ready_v[0] = 1'b1;
    start_v[0] = 1'b1;
    tick();                                  // now cycle 1
    start_v[0] = 1'b0;
    chk("t1_valid_c1", 0, int'(d_valid[0]), 1);
    for (int c = 1; c <= 6; c++) begin
      if (c == 3) begin
        chk("t1_eol_c3",  0, int'(d_eol[0]),  1);
        chk("t1_last_c3", 0, int'(d_last[0]), 0);
      end
      if (c == 6) chk("t1_last_c6", 0, int'(d_last[0]), 1);
      tick();
    end
    chk("t1_done_c7", 0, int'(d_done[0]), 1);
    tick();
    chk("t1_busy_c8", 0, int'(d_busy[0]), 0);
    chk_log6("t1_log");
    tick();

    // T2: ready pattern 1,0,0 repeating
    log0.delete();
    d0 = done_cnt[0];
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    seen = 0;
    lastc = -1;
    for (int i = 0; i < 60; i++) begin
      ready_v[0] = (i % 3 == 0);
      if (i == 2) chk("t2_hold_x", 0, int'(d_x[0]), 1);
      if (d_valid[0] && ready_v[0]) lastc = i;
      tick();
      if (d_done[0]) begin
        seen = 1;
        chk("t2_done_after_last", 0, i, lastc);
        break;
      end
    end
    chk("t2_done_seen", 0, seen, 1);
    chk_log6("t2_log");
    tick();
    chk("t2_done_once", 0, done_cnt[0] - d0, 1);

    // T3: start pulses at cycles 3 and 7 are ignored
    log0.delete();
    d0 = done_cnt[0];
    ready_v[0] = 1'b1;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      start_v[0] = (c == 3 || c == 7);
      tick();
    end
    start_v[0] = 1'b0;
    chk("t3_done_once", 0, done_cnt[0] - d0, 1);
    chk("t3_idle_busy", 0, int'(d_busy[0]), 0);
    chk_log6("t3_log");

    // T4: reset at the 4th transfer
    d0 = done_cnt[0];
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) rst_v[0] = 1'b1;
      tick();
    end
    rst_v[0] = 1'b0;
    chk("t4_valid", 0, int'(d_valid[0]), 0);
    chk("t4_busy",  0, int'(d_busy[0]),  0);
    chk("t4_x",     0, int'(d_x[0]),     0);
    chk("t4_y",     0, int'(d_y[0]),     0);
    tick();
    chk("t4_no_done", 0, done_cnt[0] - d0, 0);
    log0.delete();
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    run0_to_done("t4");
    chk_log6("t4_log");
    tick();

    // T5a: 1x1
    ready_v[1] = 1'b1;
    start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    chk("t5_valid", 1, int'(d_valid[1]), 1);
    chk("t5_eol",   1, int'(d_eol[1]),   1);
    chk("t5_last",  1, int'(d_last[1]),  1);
    tick();
    chk("t5_done",  1, int'(d_done[1]),  1);
    tick();
    chk("t5_busy",  1, int'(d_busy[1]),  0);
    chk("t5_done_once", 1, done_cnt[1], 1);

    // T5b: 4x1, last coincides with eol at x=3
    ready_v[2] = 1'b1;
    start_v[2] = 1'b1;
    tick();
    start_v[2] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) chk("t5b_last_x2", 2, int'(d_last[2]), 0);
      if (c == 3) begin
        chk("t5b_x3",    2, int'(d_x[2]),    3);
        chk("t5b_eol3",  2, int'(d_eol[2]),  1);
        chk("t5b_last3", 2, int'(d_last[2]), 1);
      end
      tick();
    end
    chk("t5b_done", 2, int'(d_done[2]), 1);
    tick();

`ifdef SCAN_SEQ_ABORT_EN
    // T6: abort at (1,1) with ready high; that transfer still counts
    log0.delete();
    d0 = done_cnt[0];
    ready_v[0] = 1'b1;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) begin
        chk("t6_x_at_abort", 0, int'(d_x[0]), 1);
        chk("t6_y_at_abort", 0, int'(d_y[0]), 1);
        abort_v[0] = 1'b1;
      end
      tick();
    end
    abort_v[0] = 1'b0;
    chk("t6_valid", 0, int'(d_valid[0]), 0);
    chk("t6_busy",  0, int'(d_busy[0]),  0);
    chk("t6_xfers", 0, log0.size(), 5);
    chk("t6_lastxfer", 0, (log0.size() == 5) ? log0[4] : -1, 17);
    tick();
    tick();
    chk("t6_no_done", 0, done_cnt[0] - d0, 0);
    // abort together with start in IDLE
    abort_v[0] = 1'b1;
    start_v[0] = 1'b1;
    tick();
    abort_v[0] = 1'b0;
    start_v[0] = 1'b0;
    chk("t6_idle_busy",  0, int'(d_busy[0]),  0);
    chk("t6_idle_valid", 0, int'(d_valid[0]), 0);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_scan_seq
